// File: rtl/bw_text_console.sv
// bw_text_console: turns a byte stream into masked 32-bit writes to a write-only
// 80x30 text screenbuffer, tracking a cursor and clearing rows on wrap.
module bw_text_console #(
    parameter logic [31:0] SCREENBUFFER_BASE_ADDR = 32'h8000,
    parameter int unsigned COLS           = 80,
    parameter int unsigned ROWS           = 30,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  wmask,
    output logic        wen,
    output logic        ren,
    input  logic        ready,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, PUT, NEWLINE, CLR_ROW, CLR_ALL, BS_WR} state_t;

    localparam logic [9:0]  ROW_WORDS = 10'(COLS / 4);
    localparam logic [9:0]  ALL_WORDS = 10'(ROWS * COLS / 4);
    localparam logic [31:0] BLANK     = 32'h2020_2020;

    state_t      state, state_n;
    logic [6:0]  col_n;
    logic [4:0]  row_n, row_next;
    logic [9:0]  cnt, cnt_n;
    logic        wen_n;
    logic [31:0] addr_n, wdata_n;
    logic [3:0]  wmask_n;
    logic [7:0]  tab_col;

    function automatic logic [11:0] char_idx(input logic [4:0] r, input logic [6:0] c);
        return 12'(r) * 12'(COLS) + 12'(c);
    endfunction

    function automatic logic [31:0] word_addr(input logic [9:0] w);
        return SCREENBUFFER_BASE_ADDR + {20'd0, w, 2'b00};
    endfunction

    function automatic logic [31:0] char_addr(input logic [4:0] r, input logic [6:0] c);
        logic [11:0] idx;
        idx = char_idx(r, c);
        return word_addr(idx[11:2]);
    endfunction

    function automatic logic [3:0] char_lane(input logic [4:0] r, input logic [6:0] c);
        logic [11:0] idx;
        idx = char_idx(r, c);
        return 4'b0001 << idx[1:0];
    endfunction

    assign char_ready = (state == IDLE) && !rst;
    assign busy       = (state != IDLE);
    assign ren        = 1'b0;
    assign tab_col    = ({1'b0, cursor_col} | 8'd7) + 8'd1;
    assign row_next   = (cursor_row == 5'(ROWS - 1)) ? 5'd0 : cursor_row + 5'd1;

    // In bus states, wen=0 means the previous transfer has completed and its
    // mandatory idle gap is now elapsing; the next transfer or exit follows.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_n = state;
        col_n   = cursor_col;
        row_n   = cursor_row;
        cnt_n   = cnt;
        wen_n   = wen;
        addr_n  = addr;
        wdata_n = wdata;
        wmask_n = wmask;
        unique case (state)
            IDLE: if (char_valid) begin
                case (char_data)
                    8'h0A: begin col_n = '0; state_n = NEWLINE; end
                    8'h0D: col_n = '0;
                    8'h08: if (cursor_col != 7'd0) begin
                        col_n   = cursor_col - 7'd1;
                        state_n = BS_WR;
                        wen_n   = 1'b1;
                        addr_n  = char_addr(cursor_row, cursor_col - 7'd1);
                        wmask_n = char_lane(cursor_row, cursor_col - 7'd1);
                        wdata_n = BLANK;
                    end
                    8'h09: if (tab_col >= 8'(COLS)) begin
                        col_n   = '0;
                        state_n = NEWLINE;
                    end else begin
                        col_n = tab_col[6:0];
                    end
                    8'h0C: begin cnt_n = '0; state_n = CLR_ALL; end
                    default: if (char_data >= 8'h20) begin
                        state_n = PUT;
                        wen_n   = 1'b1;
                        addr_n  = char_addr(cursor_row, cursor_col);
                        wmask_n = char_lane(cursor_row, cursor_col);
                        wdata_n = {4{char_data}};
                    end
                endcase
            end
            PUT: if (wen) begin
                if (ready) begin
                    wen_n = 1'b0;
                    col_n = (cursor_col == 7'(COLS - 1)) ? 7'd0 : cursor_col + 7'd1;
                end
            end else begin
                // Column 0 after a put can only mean the row just wrapped.
                state_n = (cursor_col == 7'd0) ? NEWLINE : IDLE;
            end
            BS_WR: if (wen) begin
                if (ready) wen_n = 1'b0;
            end else begin
                state_n = IDLE;
            end
            NEWLINE: begin
                row_n   = row_next;
                cnt_n   = '0;
                state_n = CLR_ROW;
            end
            CLR_ROW: if (wen) begin
                if (ready) begin wen_n = 1'b0; cnt_n = cnt + 10'd1; end
            end else if (cnt == ROW_WORDS) begin
                state_n = IDLE;
            end else begin
                wen_n   = 1'b1;
                addr_n  = word_addr(10'(cursor_row) * ROW_WORDS + cnt);
                wmask_n = 4'hF;
                wdata_n = BLANK;
            end
            CLR_ALL: if (wen) begin
                if (ready) begin wen_n = 1'b0; cnt_n = cnt + 10'd1; end
            end else if (cnt == ALL_WORDS) begin
                col_n   = '0;
                row_n   = '0;
                state_n = IDLE;
            end else begin
                wen_n   = 1'b1;
                addr_n  = word_addr(cnt);
                wmask_n = 4'hF;
                wdata_n = BLANK;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: reset is asynchronous, so an in-flight write is dropped the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLEAR_ON_RESET ? CLR_ALL : IDLE;
            cursor_col <= '0;
            cursor_row <= '0;
            cnt        <= '0;
            wen        <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            wmask      <= '0;
        end else begin
            state      <= state_n;
            cursor_col <= col_n;
            cursor_row <= row_n;
            cnt        <= cnt_n;
            wen        <= wen_n;
            addr       <= addr_n;
            wdata      <= wdata_n;
            wmask      <= wmask_n;
        end
    end
endmodule

// File: tb/tb_bw_text_console.sv
// tb_bw_text_console: directed bench with a screen-level model that predicts every
// bus write and the cursor, plus literal expectations for the key scenarios.
module tb_bw_text_console;
    localparam int          COLS = 80;
    localparam int          ROWS = 30;
    localparam logic [31:0] BASE = 32'h8000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_valid = 1'b0;
    logic        ready = 1'b1;
    logic        char_ready, wen, ren, busy;
    logic [31:0] addr, wdata;
    logic [3:0]  wmask;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } wr_t;

    wr_t exp_q[$];
    wr_t log_q[$];
    int  n_checks = 0;
    int  n_err    = 0;
    int  delay    = 0;
    int  mrow     = 0;
    int  mcol     = 0;

    bw_text_console dut (
        .clk(clk), .rst(rst), .char_data(char_data), .char_valid(char_valid),
        .char_ready(char_ready), .addr(addr), .wdata(wdata), .wmask(wmask),
        .wen(wen), .ren(ren), .ready(ready), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---- screen-level model ----
    task automatic push_word(input int w);
        wr_t e;
        e.a = BASE + 32'(w * 4);
        e.d = 32'h2020_2020;
        e.m = 4'hF;
        exp_q.push_back(e);
    endtask

    task automatic push_char(input int r, input int c, input logic [7:0] b);
        wr_t e;
        int  idx;
        idx = r * COLS + c;
        e.a = BASE + 32'((idx / 4) * 4);
        e.d = {4{b}};
        e.m = 4'(1 << (idx % 4));
        exp_q.push_back(e);
    endtask

    task automatic model_newline();
        mrow = (mrow + 1) % ROWS;
        for (int w = 0; w < COLS / 4; w++) push_word(mrow * (COLS / 4) + w);
    endtask

    task automatic model_reset();
        exp_q.delete();
        mrow = 0;
        mcol = 0;
        for (int w = 0; w < ROWS * COLS / 4; w++) push_word(w);
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (b)
            8'h0A: begin mcol = 0; model_newline(); end
            8'h0D: mcol = 0;
            8'h08: if (mcol > 0) begin mcol--; push_char(mrow, mcol, 8'h20); end
            8'h09: begin
                mcol = (mcol | 7) + 1;
                if (mcol >= COLS) begin mcol = 0; model_newline(); end
            end
            8'h0C: begin
                for (int w = 0; w < ROWS * COLS / 4; w++) push_word(w);
                mrow = 0;
                mcol = 0;
            end
            default: if (b >= 8'h20) begin
                push_char(mrow, mcol, b);
                mcol++;
                if (mcol == COLS) begin mcol = 0; model_newline(); end
            end
        endcase
    endtask

    // ---- responder: ready after `delay` wen cycles, or constantly high ----
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (wen) wcnt++;
            else wcnt = 0;
            ready = (delay == 0) || (wcnt > delay);
        end
    end

    // ---- compare process ----
    initial begin
        logic        held;
        logic [31:0] pa, pd;
        logic [3:0]  pm;
        wr_t         e, o;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && wen) begin
                check("wen_excl_char_ready", char_ready, 1'b0);
                check("ren_low", ren, 1'b0);
                if (held) begin
                    check("hold_addr", addr, pa);
                    check("hold_wdata", wdata, pd);
                    check("hold_wmask", wmask, pm);
                end
                if (ready) begin
                    o.a = addr; o.d = wdata; o.m = wmask;
                    log_q.push_back(o);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_write: got addr %h wdata %h wmask %h expected none",
                                 addr, wdata, wmask);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", addr, e.a);
                        check("wr_wdata", wdata, e.d);
                        check("wr_wmask", wmask, e.m);
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    pa = addr; pd = wdata; pm = wmask;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!char_ready && t < 4000) begin @(negedge clk); t++; end
        if (!char_ready) begin
            check("send_timeout", 32'(t), 32'd0);
            return;
        end
        char_data  = b;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!(char_ready && !busy && !wen) && t < 4000) begin @(negedge clk); t++; end
        check("idle_reached", {31'd0, char_ready && !busy}, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);
        check("cursor_col", cursor_col, mcol);
        check("cursor_row", cursor_row, mrow);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int    base, t;
        string s;
        #1 rst = 1'b1;
        #3;
        check("rst_wen", wen, 1'b0);
        check("rst_addr", addr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_wmask", wmask, 4'h0);
        check("rst_ren", ren, 1'b0);
        check("rst_char_ready", char_ready, 1'b0);
        check("rst_col", cursor_col, 7'd0);
        check("rst_row", cursor_row, 5'd0);
        check("rst_busy", busy, 1'b1);
        repeat (2) @(negedge clk);
        model_reset();
        base = log_q.size();
        rst = 1'b0;
        wait_idle();
        check("boot_count", 32'(log_q.size() - base), 32'd600);
        check("boot_first", log_q[base].a, 32'h8000);
        check("boot_last", log_q[base + 599].a, 32'h895C);
        check("boot_data", log_q[base + 599].d, 32'h2020_2020);
        check("boot_mask", log_q[base + 599].m, 4'hF);
        check("boot_busy", busy, 1'b0);
        check("boot_char_ready", char_ready, 1'b1);

        // Five printable bytes across a word boundary
        s = "ABCDE";
        base = log_q.size();
        for (int i = 0; i < s.len(); i++) send(s[i]);
        wait_idle();
        check("abcde_count", 32'(log_q.size() - base), 32'd5);
        check("a_addr", log_q[base].a, 32'h8000);
        check("a_data", log_q[base].d, 32'h4141_4141);
        check("a_mask", log_q[base].m, 4'h1);
        check("d_mask", log_q[base + 3].m, 4'h8);
        check("e_addr", log_q[base + 4].a, 32'h8004);
        check("e_mask", log_q[base + 4].m, 4'h1);
        check("abcde_col", cursor_col, 7'd5);

        // Slow responder: the compare process checks held bus values
        delay = 3;
        base = log_q.size();
        send(8'h78);
        send(8'h79);
        wait_idle();
        delay = 0;
        check("slow_count", 32'(log_q.size() - base), 32'd2);

        // Printable-byte latency with ready already high
        send(8'h54);
        check("lat_wen_n1", wen, 1'b1);
        check("lat_cr_n1", char_ready, 1'b0);
        @(posedge clk); #1;
        check("lat_wen_gap", wen, 1'b0);
        check("lat_cr_gap", char_ready, 1'b0);
        @(posedge clk); #1;
        check("lat_cr_n3", char_ready, 1'b1);
        wait_idle();

        // Tab from column 3, then backspaces
        send(8'h0D);
        send(8'h61); send(8'h62); send(8'h63);
        send(8'h09);
        wait_idle();
        check("tab_col", cursor_col, 7'd8);
        base = log_q.size();
        send(8'h08);
        wait_idle();
        check("bs_count", 32'(log_q.size() - base), 32'd1);
        check("bs_addr", log_q[base].a, 32'h8004);
        check("bs_mask", log_q[base].m, 4'h8);
        check("bs_data", log_q[base].d, 32'h2020_2020);
        check("bs_col", cursor_col, 7'd7);
        send(8'h0D);
        base = log_q.size();
        send(8'h08);
        send(8'h01);
        send(8'h1F);
        wait_idle();
        check("bs0_nowrite", 32'(log_q.size() - base), 32'd0);
        check("bs0_col", cursor_col, 7'd0);

        // Ten tabs from column 0 wrap to the next row
        base = log_q.size();
        for (int i = 0; i < 10; i++) send(8'h09);
        wait_idle();
        check("tabwrap_row", cursor_row, 5'd1);
        check("tabwrap_clears", 32'(log_q.size() - base), 32'd20);

        // Last cell of the screen: put then wrap to row 0 with a row clear
        for (int i = 0; i < 28; i++) send(8'h0A);
        for (int i = 0; i < 79; i++) send(8'h7A);
        wait_idle();
        check("corner_col", cursor_col, 7'd79);
        check("corner_row", cursor_row, 5'd29);
        base = log_q.size();
        send(8'h5A);
        wait_idle();
        check("z_count", 32'(log_q.size() - base), 32'd21);
        check("z_addr", log_q[base].a, 32'h895C);
        check("z_mask", log_q[base].m, 4'h8);
        check("z_data", log_q[base].d, 32'h5A5A_5A5A);
        check("z_clr_first", log_q[base + 1].a, 32'h8000);
        check("z_clr_last", log_q[base + 20].a, 32'h804C);
        check("z_row", cursor_row, 5'd0);
        check("z_col", cursor_col, 7'd0);

        // Thirty newlines wrap through row 29 back to row 0
        for (int i = 0; i < 30; i++) send(8'h0A);
        wait_idle();
        check("nl_wrap_row", cursor_row, 5'd0);

        // Reset in the middle of a full-screen clear
        delay = 3;
        send(8'h0C);
        base = log_q.size();
        t = 0;
        while (log_q.size() < base + 5 && t < 200) begin @(negedge clk); t++; end
        t = 0;
        do begin @(posedge clk); #2; t++; end while (!wen && t < 50);
        check("midclr_wen_before", wen, 1'b1);
        rst = 1'b1;
        #1;
        check("midclr_wen_async", wen, 1'b0);
        check("midclr_char_ready", char_ready, 1'b0);
        check("midclr_busy", busy, 1'b1);
        model_reset();
        delay = 0;
        repeat (2) @(negedge clk);
        base = log_q.size();
        rst = 1'b0;
        wait_idle();
        check("restart_count", 32'(log_q.size() - base), 32'd600);
        check("restart_first", log_q[base].a, 32'h8000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
